// File: rtl/sram_serial_feeder.sv
// rtl/sram_serial_feeder.sv - FIFO-buffered {addr,data} frame sender for the SRAM serial loader
// Queues host writes and replays each as an LSB-first serial frame, re-arming the loader between frames.
module sram_serial_feeder #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH        = 4,
  parameter int RDY_TIMEOUT       = 8
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic                         WR_EN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] WR_ADDR,
  input  logic [MEMORY_DATA_WIDTH-1:0] WR_DATA,
  input  logic                         ERR_CLR,
  output logic                         FULL,
  output logic                         BUSY,
  output logic                         DONE,
  output logic                         ERR,
  output logic                         OVF,
  output logic                         LDR_BGN,
  output logic                         LDR_LOAD_N,
  output logic                         LDR_SI,
  input  logic                         LDR_RDY
);

  localparam int W  = MEMORY_ADDR_WIDTH + MEMORY_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(W + 1);
  localparam int TW = $clog2(RDY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_SHIFT,
    S_WAIT,
    S_CLR
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   fifo_q [FIFO_DEPTH];
  logic [W-1:0]   fifo_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   sr_q, sr_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           full_q, full_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           ovf_q, ovf_d;
  logic           bgn_q, bgn_d;
  logic           load_n_q, load_n_d;
  logic           si_q, si_d;
  logic           push, pop, err_set;
  logic [W-1:0]   head;

  always_comb begin
    // The head is only consumed in CLR, so a full FIFO can still accept a write that cycle.
    pop     = (state_q == S_CLR);
    push    = WR_EN && ((count_q != CW'(FIFO_DEPTH)) || pop);
    head    = fifo_q[rd_ptr_q];

    fifo_d  = fifo_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {WR_ADDR, WR_DATA};
    end
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);

    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    tmr_d     = tmr_q;
    si_d      = 1'b0;
    done_d    = 1'b0;
    err_set   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d = S_ARM;
        end
      end
      S_ARM: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
        si_d      = head[0];
        sr_d      = head >> 1;
      end
      S_SHIFT: begin
        if (bit_cnt_q == BW'(W - 1)) begin
          state_d = S_WAIT;
          tmr_d   = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
          si_d      = sr_q[0];
          sr_d      = sr_q >> 1;
        end
      end
      S_WAIT: begin
        if (LDR_RDY) begin
          state_d = S_CLR;
          done_d  = 1'b1;
        end else if (tmr_q >= TW'(RDY_TIMEOUT - 1)) begin
          state_d = S_CLR;
          err_set = 1'b1;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_CLR: begin
        state_d = (count_d != '0) ? S_ARM : S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    bgn_d    = (state_d == S_ARM) || (state_d == S_SHIFT) || (state_d == S_WAIT);
    load_n_d = (state_d != S_ARM);
    full_d   = (count_d == CW'(FIFO_DEPTH));
    busy_d   = (count_d != '0) || (state_d != S_IDLE);
    err_d    = err_set || (err_q && !ERR_CLR);
    ovf_d    = (WR_EN && !push) || (ovf_q && !ERR_CLR);
  end

  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      state_q   <= S_IDLE;
      fifo_q    <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      tmr_q     <= '0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ovf_q     <= 1'b0;
      bgn_q     <= 1'b0;
      load_n_q  <= 1'b1;
      si_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      fifo_q    <= fifo_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      tmr_q     <= tmr_d;
      full_q    <= full_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ovf_q     <= ovf_d;
      bgn_q     <= bgn_d;
      load_n_q  <= load_n_d;
      si_q      <= si_d;
    end
  end

  assign FULL       = full_q;
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ERR        = err_q;
  assign OVF        = ovf_q;
  assign LDR_BGN    = bgn_q;
  assign LDR_LOAD_N = load_n_q;
  assign LDR_SI     = si_q;

endmodule

// File: tb/tb_sram_serial_feeder.sv
// tb/tb_sram_serial_feeder.sv - scoreboard bench for sram_serial_feeder with a behavioural loader
`timescale 1ns/1ps
module tb_sram_serial_feeder;

  localparam int W = 17;

  logic       CLK = 1'b0;
  logic       BGN = 1'b0;
  logic       WR_EN = 1'b0;
  logic [8:0] WR_ADDR = '0;
  logic [7:0] WR_DATA = '0;
  logic       ERR_CLR = 1'b0;
  logic       LDR_RDY = 1'b0;
  logic       FULL, BUSY, DONE, ERR, OVF, LDR_BGN, LDR_LOAD_N, LDR_SI;

  int total = 0;
  int bad = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_frame;
  logic [7:0]   mem [0:511];
  int           lcnt = -1;
  logic [W-1:0] lsr = '0;
  logic         rdy_en = 1'b1;

  sram_serial_feeder #(
    .MEMORY_DATA_WIDTH(8),
    .MEMORY_ADDR_WIDTH(9),
    .FIFO_DEPTH(4),
    .RDY_TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .BGN(BGN),
    .WR_EN(WR_EN),
    .WR_ADDR(WR_ADDR),
    .WR_DATA(WR_DATA),
    .ERR_CLR(ERR_CLR),
    .FULL(FULL),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR),
    .OVF(OVF),
    .LDR_BGN(LDR_BGN),
    .LDR_LOAD_N(LDR_LOAD_N),
    .LDR_SI(LDR_SI),
    .LDR_RDY(LDR_RDY)
  );

  always #5 CLK = ~CLK;

  // Behavioural loader: arm on LOAD_N, capture W bits, raise RDY one cycle after the last bit.
  always @(posedge CLK) begin
    if (LDR_BGN !== 1'b1) begin
      lcnt = -1;
      LDR_RDY <= 1'b0;
    end else if (LDR_LOAD_N === 1'b0) begin
      lcnt = 0;
    end else if (lcnt >= 0 && lcnt < W) begin
      lsr[lcnt] = LDR_SI;
      lcnt++;
      if (lcnt == W) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL frame_unexpected got=%h want=none", lsr);
        end else begin
          exp_frame = exp_q.pop_front();
          if (lsr !== exp_frame) begin
            bad++;
            $display("FAIL frame_content got=%h want=%h", lsr, exp_frame);
          end
        end
        if (rdy_en) mem[lsr[16:8]] = lsr[7:0];
      end
    end else if (lcnt == W && rdy_en) begin
      LDR_RDY <= 1'b1;
    end
  end

  task automatic push(input logic [8:0] a, input logic [7:0] d, input bit accept);
    WR_EN = 1'b1;
    WR_ADDR = a;
    WR_DATA = d;
    if (accept) exp_q.push_back({a, d});
    @(negedge CLK);
    WR_EN = 1'b0;
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (DONE !== 1'b1 && n < max) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic test_reset();
    BGN = 1'b0;
    repeat (2) @(negedge CLK);
    total++;
    if ({LDR_BGN, LDR_LOAD_N, LDR_SI, DONE, ERR, OVF, FULL, BUSY} !== 8'b0100_0000) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=01000000",
               {LDR_BGN, LDR_LOAD_N, LDR_SI, DONE, ERR, OVF, FULL, BUSY});
    end
    BGN = 1'b1;
    repeat (2) @(negedge CLK);
    total++;
    if ({LDR_BGN, LDR_LOAD_N, BUSY} !== 3'b010) begin
      bad++;
      $display("FAIL idle_after_reset got=%b want=010", {LDR_BGN, LDR_LOAD_N, BUSY});
    end
  endtask

  task automatic test_single();
    int n;
    int ndone;
    int si_list[W] = '{0,0,1,1,1,1,0,0,1,0,1,0,0,1,0,1,1};
    push(9'h1A5, 8'h3C, 1'b1);
    total++;
    if (BUSY !== 1'b1) begin
      bad++;
      $display("FAIL single_busy got=%b want=1", BUSY);
    end
    @(negedge CLK);
    total++;
    if ({LDR_BGN, LDR_LOAD_N} !== 2'b10) begin
      bad++;
      $display("FAIL single_arm got=%b want=10", {LDR_BGN, LDR_LOAD_N});
    end
    wait_done(40, n);
    total++;
    if (n !== 20) begin
      bad++;
      $display("FAIL single_done_latency got=%0d want=20", n);
    end
    ndone = 0;
    repeat (10) begin
      @(negedge CLK);
      if (DONE === 1'b1) ndone++;
    end
    total++;
    if (ndone !== 0) begin
      bad++;
      $display("FAIL single_extra_done got=%0d want=0", ndone);
    end
    for (int k = 0; k < W; k++) begin
      total++;
      if (lsr[k] !== si_list[k][0]) begin
        bad++;
        $display("FAIL single_si_bit%0d got=%b want=%0d", k, lsr[k], si_list[k]);
      end
    end
    total++;
    if (mem[9'h1A5] !== 8'h3C) begin
      bad++;
      $display("FAIL single_mem got=%h want=3c", mem[9'h1A5]);
    end
    total++;
    if ({ERR, BUSY} !== 2'b00) begin
      bad++;
      $display("FAIL single_err_busy got=%b want=00", {ERR, BUSY});
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int i = 0; i < 4; i++) push(9'(9'h010 + i), 8'(8'hA0 + 8'(i * 7)), 1'b1);
    total++;
    if (FULL !== 1'b1) begin
      bad++;
      $display("FAIL b2b_full got=%b want=1", FULL);
    end
    push(9'h0FF, 8'h55, 1'b0);
    total++;
    if ({OVF, FULL} !== 2'b11) begin
      bad++;
      $display("FAIL b2b_ovf got=%b want=11", {OVF, FULL});
    end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    total++;
    if (OVF !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ovf_clr got=%b want=0", OVF);
    end
    wait_done(60, n);
    total++;
    if (n >= 60) begin
      bad++;
      $display("FAIL b2b_first_done got=timeout want=done");
    end
    for (int f = 1; f < 4; f++) begin
      total++;
      if (LDR_BGN !== 1'b0) begin
        bad++;
        $display("FAIL b2b_gap_low%0d got=%b want=0", f, LDR_BGN);
      end
      @(negedge CLK);
      total++;
      if (LDR_BGN !== 1'b1) begin
        bad++;
        $display("FAIL b2b_gap_rearm%0d got=%b want=1", f, LDR_BGN);
      end
      wait_done(60, n);
      total++;
      if (n + 1 !== 21) begin
        bad++;
        $display("FAIL b2b_spacing%0d got=%0d want=21", f, n + 1);
      end
    end
    @(negedge CLK);
    total++;
    if (exp_q.size() !== 0 || BUSY !== 1'b0) begin
      bad++;
      $display("FAIL b2b_drain got=%0d/%b want=0/0", exp_q.size(), BUSY);
    end
  endtask

  task automatic test_push_in_clr();
    int n;
    for (int i = 0; i < 4; i++) push(9'(9'h100 + i), 8'(8'h11 * (i + 1)), 1'b1);
    wait_done(60, n);
    total++;
    if (FULL !== 1'b1) begin
      bad++;
      $display("FAIL clr_full_before got=%b want=1", FULL);
    end
    push(9'h1FE, 8'hE7, 1'b1);
    total++;
    if ({FULL, OVF} !== 2'b10) begin
      bad++;
      $display("FAIL clr_push got=%b want=10", {FULL, OVF});
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge CLK);
      wait_done(60, n);
      total++;
      if (n !== 20) begin
        bad++;
        $display("FAIL clr_frame%0d got=%0d want=20", i, n);
      end
    end
    @(negedge CLK);
    total++;
    if (exp_q.size() !== 0 || OVF !== 1'b0) begin
      bad++;
      $display("FAIL clr_drain got=%0d/%b want=0/0", exp_q.size(), OVF);
    end
  endtask

  task automatic test_timeout();
    int n;
    bit saw_done;
    rdy_en = 1'b0;
    push(9'h0AA, 8'h5A, 1'b1);
    push(9'h0BB, 8'h6B, 1'b1);
    n = 0;
    saw_done = 1'b0;
    while (ERR !== 1'b1 && n < 60) begin
      @(negedge CLK);
      n++;
      if (DONE === 1'b1) saw_done = 1'b1;
    end
    rdy_en = 1'b1;
    total++;
    if (n !== 26) begin
      bad++;
      $display("FAIL timeout_err_time got=%0d want=26", n);
    end
    total++;
    if (saw_done !== 1'b0) begin
      bad++;
      $display("FAIL timeout_done got=%b want=0", saw_done);
    end
    @(negedge CLK);
    wait_done(60, n);
    total++;
    if (n !== 20) begin
      bad++;
      $display("FAIL timeout_next_frame got=%0d want=20", n);
    end
    total++;
    if (mem[9'h0BB] !== 8'h6B || ERR !== 1'b1) begin
      bad++;
      $display("FAIL timeout_next_mem got=%h/%b want=6b/1", mem[9'h0BB], ERR);
    end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    total++;
    if (ERR !== 1'b0) begin
      bad++;
      $display("FAIL timeout_err_clr got=%b want=0", ERR);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    push(9'h033, 8'hC3, 1'b1);
    repeat (9) @(negedge CLK);
    total++;
    if (lcnt !== 7) begin
      bad++;
      $display("FAIL midrst_position got=%0d want=7", lcnt);
    end
    BGN = 1'b0;
    #1;
    total++;
    if ({LDR_BGN, LDR_LOAD_N, BUSY} !== 3'b010) begin
      bad++;
      $display("FAIL midrst_outputs got=%b want=010", {LDR_BGN, LDR_LOAD_N, BUSY});
    end
    exp_q.delete();
    @(negedge CLK);
    BGN = 1'b1;
    @(negedge CLK);
    push(9'h144, 8'h81, 1'b1);
    wait_done(60, n);
    total++;
    if (n !== 21) begin
      bad++;
      $display("FAIL midrst_resend got=%0d want=21", n);
    end
    total++;
    if (exp_q.size() !== 0 || mem[9'h144] !== 8'h81) begin
      bad++;
      $display("FAIL midrst_frame got=%0d/%h want=0/81", exp_q.size(), mem[9'h144]);
    end
  endtask

  task automatic test_idle();
    repeat (5) @(negedge CLK);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      total++;
      if ({LDR_BGN, LDR_LOAD_N, DONE} !== 3'b010) begin
        bad++;
        $display("FAIL idle_cycle%0d got=%b want=010", i, {LDR_BGN, LDR_LOAD_N, DONE});
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_push_in_clr();
    test_timeout();
    test_reset_mid();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
